// File: rtl/tvbg_sys_ctl.sv
// System control: clock-enable divider, reset stretcher, button debounce with press/long-press pulses.
// Define TVBG_LONG_PRESS_EN to build the per-channel long-press counters; otherwise btn_long_out is tied low.
module tvbg_sys_ctl #(
  parameter int DIV             = 3,
  parameter int RST_CYCLES      = 65536,
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int LONG_CYCLES     = 8000000
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic [N_BTN-1:0] btn_in,
  output logic             ce_out,
  output logic             clk_div_out,
  output logic             rst_out,
  output logic [N_BTN-1:0] btn_level_out,
  output logic [N_BTN-1:0] btn_press_out,
  output logic [N_BTN-1:0] btn_long_out
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
  localparam logic [RST_W-1:0] RST_MAX    = RST_W'(RST_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DIV_W-1:0]            div_cnt_q, div_cnt_d;
  logic                        ce_q, ce_d;
  logic                        clk_div_q, clk_div_d;
  logic [RST_W-1:0]            rst_cnt_q, rst_cnt_d;
  logic                        rst_q, rst_d;
  logic [N_BTN-1:0]            sync1_q, sync1_d;
  logic [N_BTN-1:0]            sync2_q, sync2_d;
  logic [N_BTN-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [N_BTN-1:0]            level_q, level_d;
  logic [N_BTN-1:0]            press_q, press_d;

  always_comb begin
    div_cnt_d = div_cnt_q - 1'b1;
    ce_d      = 1'b0;
    clk_div_d = clk_div_q;
    if (div_cnt_q == '0) begin
      div_cnt_d = DIV_RELOAD;
      ce_d      = 1'b1;
      clk_div_d = ~clk_div_q;
    end

    // Saturating count: rst_out drops on the edge the count reaches RST_CYCLES.
    rst_cnt_d = (rst_cnt_q < RST_MAX) ? rst_cnt_q + 1'b1 : rst_cnt_q;
    rst_d     = (rst_cnt_d < RST_MAX);

    sync1_d = (BTN_ACTIVE_LOW != 0) ? ~btn_in : btn_in;
    sync2_d = sync1_q;

    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        level_d[i]  = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end

    // Gated by the next rst_out so no pulse coincides with the stretched reset.
    press_d = level_d & ~level_q & {N_BTN{~rst_d}};
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      div_cnt_q <= DIV_RELOAD;
      ce_q      <= 1'b0;
      clk_div_q <= 1'b0;
      rst_cnt_q <= '0;
      rst_q     <= 1'b1;
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_cnt_q  <= '0;
      level_q   <= '0;
      press_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      ce_q      <= ce_d;
      clk_div_q <= clk_div_d;
      rst_cnt_q <= rst_cnt_d;
      rst_q     <= rst_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
    end
  end

`ifdef TVBG_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

  logic [N_BTN-1:0][LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic [N_BTN-1:0]             armed_q, armed_d;
  logic [N_BTN-1:0]             long_q, long_d;

  always_comb begin
    long_cnt_d = long_cnt_q;
    armed_d    = armed_q;
    long_d     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!level_q[i]) begin
        long_cnt_d[i] = '0;
        armed_d[i]    = 1'b1;
      end else begin
        if (long_cnt_q[i] != LONG_MAX) long_cnt_d[i] = long_cnt_q[i] + 1'b1;
        if (armed_q[i] && long_cnt_d[i] == LONG_MAX) begin
          long_d[i]  = ~rst_d;
          armed_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      long_cnt_q <= '0;
      armed_q    <= '1;
      long_q     <= '0;
    end else begin
      long_cnt_q <= long_cnt_d;
      armed_q    <= armed_d;
      long_q     <= long_d;
    end
  end

  assign btn_long_out = long_q;
`else
  assign btn_long_out = '0;
`endif

  assign ce_out        = ce_q;
  assign clk_div_out   = clk_div_q;
  assign rst_out       = rst_q;
  assign btn_level_out = level_q;
  assign btn_press_out = press_q;

endmodule
